// File: rtl/xgemac_rx_pkt_sink.sv
`default_nettype none
// ============================================================================
//  Module   : xgemac_rx_pkt_sink
//  Brief    : Pulls packets from the 10G MAC receive interface into a small
//             first-word-fall-through FIFO and keeps receive statistics
//             (packets, bytes, error packets, framing violations).
//  Revision : 1.0  initial release
// ============================================================================
module xgemac_rx_pkt_sink #(
   parameter int FIFO_AW = 2
) (
   input  logic          clk_156m25,
   input  logic          reset_156m25_n,
   // MAC packet read interface
   input  logic          pkt_rx_avail,
   output logic          pkt_rx_ren,
   input  logic [63:0]   pkt_rx_data,
   input  logic          pkt_rx_val,
   input  logic          pkt_rx_sop,
   input  logic          pkt_rx_eop,
   input  logic [2:0]    pkt_rx_mod,
   input  logic          pkt_rx_err,
   // downstream word stream
   output logic [63:0]   out_data,
   output logic          out_sop,
   output logic          out_eop,
   output logic          out_err,
   output logic [2:0]    out_mod,
   output logic          out_valid,
   input  logic          out_ready,
   // statistics
   input  logic          stat_clr,
   output logic [31:0]   stat_pkt_cnt,
   output logic [31:0]   stat_byte_cnt,
   output logic [15:0]   stat_err_cnt,
   output logic [15:0]   stat_frm_err_cnt
);

   localparam int             DEPTH   = 1 << FIFO_AW;
   localparam int             ENTRY_W = 70;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

   state_t               state_q;
   logic                 ren_q;
   logic [FIFO_AW:0]     count_q;
   logic [FIFO_AW:0]     count_d;
   logic [FIFO_AW-1:0]   wr_ptr_q;
   logic [FIFO_AW-1:0]   rd_ptr_q;
   logic [ENTRY_W-1:0]   mem_q [DEPTH];
   logic                 in_pkt_q;
   logic [31:0]          pkt_cnt_q;
   logic [31:0]          byte_cnt_q;
   logic [15:0]          err_cnt_q;
   logic [15:0]          frm_err_cnt_q;

   logic [FIFO_AW:0]     w_used;
   logic                 w_space_ok;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_eop_word;
   logic [ENTRY_W-1:0]   w_wr_entry;
   logic [ENTRY_W-1:0]   w_head;
   logic [3:0]           w_bytes;
   logic                 w_frm_err;

   // A read issued last cycle still has its word in flight, so it reserves a
   // slot; a pop in the current cycle is deliberately not counted as space.
   assign w_used     = count_q + {{FIFO_AW{1'b0}}, ren_q};
   assign w_space_ok = (w_used < DEPTH_C);
   assign w_eop_word = pkt_rx_val & pkt_rx_eop;

   // Read enable stops in the same cycle the eop word returns, so the MAC is
   // never asked for a word beyond the end of the packet.
   assign pkt_rx_ren = (state_q == ST_READ) & ~w_eop_word & w_space_ok;

   assign w_push     = pkt_rx_val;
   assign out_valid  = (count_q != '0);
   assign w_pop      = out_valid & out_ready;
   assign w_wr_entry = {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err};
   assign w_head     = mem_q[rd_ptr_q];

   // Outputs are forced to zero whenever the FIFO is empty (including reset),
   // so stale storage contents never leak out.
   assign out_data = out_valid ? w_head[69:6] : 64'd0;
   assign out_sop  = out_valid & w_head[5];
   assign out_eop  = out_valid & w_head[4];
   assign out_mod  = out_valid ? w_head[3:1] : 3'd0;
   assign out_err  = out_valid & w_head[0];

   // Bytes carried by the incoming word: a full word unless it ends the packet.
   assign w_bytes   = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {1'b0, pkt_rx_mod} : 4'd8;
   // sop must arrive exactly when no packet is open.
   assign w_frm_err = (pkt_rx_sop == in_pkt_q);

   // Next FIFO occupancy; simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + 1'b1;
      end else if (!w_push && w_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Packet read FSM: wait for a complete packet, read until its eop returns.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (pkt_rx_avail) state_q <= ST_READ;
            ST_READ: if (w_eop_word)   state_q <= ST_IDLE;
            default:                   state_q <= ST_IDLE;
         endcase
      end
   end

   // Remember last cycle's read enable to account for the word in flight.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         ren_q <= 1'b0;
      end else begin
         ren_q <= pkt_rx_ren;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // FIFO storage; no reset needed because outputs are gated by occupancy.
   always_ff @(posedge clk_156m25) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_wr_entry;
      end
   end

   // Packet-open tracking used for framing checks.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         in_pkt_q <= 1'b0;
      end else if (pkt_rx_val) begin
         if (pkt_rx_eop) begin
            in_pkt_q <= 1'b0;
         end else if (pkt_rx_sop) begin
            in_pkt_q <= 1'b1;
         end
      end
   end

   // Statistics counters; a clear wins over any increment in the same cycle.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         pkt_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         err_cnt_q     <= '0;
         frm_err_cnt_q <= '0;
      end else if (stat_clr) begin
         pkt_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         err_cnt_q     <= '0;
         frm_err_cnt_q <= '0;
      end else if (pkt_rx_val) begin
         byte_cnt_q <= byte_cnt_q + {28'd0, w_bytes};
         if (pkt_rx_eop) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (pkt_rx_err) err_cnt_q <= err_cnt_q + 16'd1;
         end
         if (w_frm_err) frm_err_cnt_q <= frm_err_cnt_q + 16'd1;
      end
   end

   assign stat_pkt_cnt     = pkt_cnt_q;
   assign stat_byte_cnt    = byte_cnt_q;
   assign stat_err_cnt     = err_cnt_q;
   assign stat_frm_err_cnt = frm_err_cnt_q;

endmodule
`default_nettype wire

// File: doc/xgemac_rx_pkt_sink.md
XGEMAC_RX_PKT_SINK -- requirements
Module: xgemac_rx_pkt_sink

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, meaning log2 of output FIFO depth (depth = 4).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_156m25  in  1  sole clock, shared with MAC packet interface
- reset_156m25_n  in  1  asynchronous active-low reset
- pkt_rx_avail  in  1  MAC holds at least one complete packet
- pkt_rx_ren  out  1  read enable to MAC; data returns one cycle later
- pkt_rx_data  in  64  MAC read data
- pkt_rx_val  in  1  pkt_rx_data/sop/eop/mod/err valid this cycle
- pkt_rx_sop  in  1  first word of packet
- pkt_rx_eop  in  1  last word of packet
- pkt_rx_mod  in  3  valid bytes in eop word; 0 means 8
- pkt_rx_err  in  1  packet error flag, meaningful on eop
- out_data  out  64  downstream word
- out_sop / out_eop / out_err  out  1 each  flags carried with word
- out_mod  out  3  carried with word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head when out_valid=1
- stat_clr  in  1  synchronous clear of all statistics
- stat_pkt_cnt  out  32  packets with eop received
- stat_byte_cnt  out  32  payload bytes received
- stat_err_cnt  out  16  eop words with pkt_rx_err=1
- stat_frm_err_cnt  out  16  framing violations

Function
REQ-003 SHALL implement FSM states IDLE and READ.
REQ-004 IDLE -> READ on any cycle with pkt_rx_avail=1; pkt_rx_ren SHALL be 0 in IDLE.
REQ-005 READ -> IDLE on the cycle pkt_rx_val=1 and pkt_rx_eop=1.
REQ-006 pkt_rx_ren SHALL be combinational: state==READ AND NOT (pkt_rx_val AND pkt_rx_eop) AND space_ok.
REQ-007 space_ok SHALL be (DEPTH - fifo_count - ren_q) >= 1, where ren_q = pkt_rx_ren of previous cycle; same-cycle pop SHALL NOT be credited.
REQ-008 Every cycle with pkt_rx_val=1 SHALL write {data,sop,eop,mod,err} into the FIFO, independent of FSM state; REQ-007 guarantees no overflow.
REQ-009 FIFO SHALL be first-word-fall-through: out_valid = (fifo_count != 0); head pops when out_valid AND out_ready.
REQ-010 Simultaneous push and pop SHALL leave fifo_count unchanged; a push to an empty FIFO SHALL appear on outputs the next cycle.
REQ-011 Pointers SHALL be FIFO_AW bits wrapping modulo DEPTH; fifo_count SHALL be FIFO_AW+1 bits.
REQ-012 Word byte count SHALL be 8 for non-eop words; for eop words, mod==0 ? 8 : mod.
REQ-013 On each written word, stat_byte_cnt SHALL add that word's byte count, wrapping modulo 2^32.
REQ-014 On each written eop word, stat_pkt_cnt SHALL increment; stat_err_cnt SHALL also increment if pkt_rx_err=1.
REQ-015 Internal in_pkt flag SHALL set on written sop word and clear on written eop word (sop+eop in one word leaves it clear).
REQ-016 stat_frm_err_cnt SHALL increment once per written word where (sop=1 AND in_pkt=1) or (sop=0 AND in_pkt=0); the word is still written.
REQ-017 All counters SHALL wrap; stat_clr=1 SHALL zero all four counters on the next edge, overriding any same-cycle increment.

Reset
REQ-018 reset_156m25_n=0 SHALL asynchronously force state IDLE, FIFO empty, in_pkt=0, ren_q=0, all counters 0.
REQ-019 During reset, pkt_rx_ren, out_valid, out_data, out_sop, out_eop, out_mod, out_err SHALL read 0.
REQ-020 Reset mid-packet SHALL discard buffered words; post-reset behaviour SHALL be identical to power-up.

Verification
REQ-021 3-word packet, eop mod=5, out_ready=1 -> 3 out words, sop on word 1, eop+mod=5 on word 3; pkt_cnt=1, byte_cnt=21.
REQ-022 10-word packet, out_ready=0 -> exactly 4 words buffered, pkt_rx_ren=0 thereafter; out_ready=1 -> all 10 words in order, none lost or duplicated.
REQ-023 2-word packet, pkt_rx_err=1 on eop -> out_err=1 on word 2; err_cnt=1, pkt_cnt=1.
REQ-024 sop word, then second sop word before any eop -> frm_err_cnt=1; stray non-sop word while idle -> frm_err_cnt=2.
REQ-025 stat_clr=1 in same cycle as an eop word -> all counters 0 next cycle.
REQ-026 Reset asserted mid-packet with 3 words buffered -> out_valid=0 and pkt_rx_ren=0 immediately; counters 0.
